// File: rtl/a1_clip_seq_if.sv
// A1 pixel write-path handshake: the sequencer drives request and pointer,
// the write datapath returns the acknowledge.
interface a1_clip_seq_if;
   logic        wr_req;
   logic        wr_ack;
   logic [15:0] wr_x;
   logic [15:0] wr_y;

   modport master (output wr_req, output wr_x, output wr_y, input wr_ack);
   modport slave  (input wr_req, input wr_x, input wr_y, output wr_ack);
endinterface

// File: rtl/a1_clip_seq.sv
// Blitter A1 clip sequencer: walks the A1 pointer over an inner x outer pixel
// run, requesting one write per pixel and skipping outside pixels when clipping.
module a1_clip_seq (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        start,
   input  logic        clip_en,
   input  logic [15:0] x_start,
   input  logic [15:0] y_start,
   input  logic        x_dir,
   input  logic [15:0] inner_cnt,
   input  logic [15:0] outer_cnt,
   input  logic [14:0] win_x,
   input  logic [14:0] win_y,
   a1_clip_seq_if.master wr,
   output logic        busy,
   output logic        done,
   output logic [15:0] clip_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WRITE, S_DONE} state_t;

   state_t      state_q;
   logic [15:0] x_q, y_q, xs_q;
   logic [15:0] inner_q, in_rem_q, out_rem_q;
   logic [14:0] win_x_q, win_y_q;
   logic        x_dir_q, clip_en_q;
   logic [15:0] clip_cnt_q;
   logic        wr_req_q, busy_q, done_q;

   logic        outside_s;
   state_t      adv_state_d;
   logic [15:0] x_adv_d, y_adv_d, in_adv_d, out_adv_d;
   logic        adv_done_d;

   assign outside_s = x_q[15] | y_q[15] | (x_q[14:0] >= win_x_q) | (y_q[14:0] >= win_y_q);

   // Pointer/counter update applied when leaving EVAL (clipped) or WRITE (acked).
   always_comb begin
      adv_state_d = S_EVAL;
      x_adv_d     = x_q;
      y_adv_d     = y_q;
      in_adv_d    = in_rem_q;
      out_adv_d   = out_rem_q;
      adv_done_d  = 1'b0;
      if (in_rem_q > 16'd1) begin
         x_adv_d  = x_dir_q ? (x_q - 16'd1) : (x_q + 16'd1);
         in_adv_d = in_rem_q - 16'd1;
      end else if (out_rem_q > 16'd1) begin
         x_adv_d   = xs_q;
         y_adv_d   = y_q + 16'd1;
         in_adv_d  = inner_q;
         out_adv_d = out_rem_q - 16'd1;
      end else begin
         adv_state_d = S_DONE;
         adv_done_d  = 1'b1;
      end
   end

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         x_q        <= 16'd0;
         y_q        <= 16'd0;
         xs_q       <= 16'd0;
         inner_q    <= 16'd0;
         in_rem_q   <= 16'd0;
         out_rem_q  <= 16'd0;
         win_x_q    <= 15'd0;
         win_y_q    <= 15'd0;
         x_dir_q    <= 1'b0;
         clip_en_q  <= 1'b0;
         clip_cnt_q <= 16'd0;
         wr_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q   <= 1'b0;
               wr_req_q <= 1'b0;
               if (start) begin
                  xs_q       <= x_start;
                  x_q        <= x_start;
                  y_q        <= y_start;
                  x_dir_q    <= x_dir;
                  clip_en_q  <= clip_en;
                  inner_q    <= inner_cnt;
                  in_rem_q   <= inner_cnt;
                  out_rem_q  <= outer_cnt;
                  win_x_q    <= win_x;
                  win_y_q    <= win_y;
                  clip_cnt_q <= 16'd0;
                  busy_q     <= 1'b1;
                  if ((inner_cnt == 16'd0) || (outer_cnt == 16'd0)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_EVAL;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_EVAL: begin
               if (outside_s && clip_en_q) begin
                  if (clip_cnt_q != 16'hFFFF) begin
                     clip_cnt_q <= clip_cnt_q + 16'd1;
                  end
                  state_q   <= adv_state_d;
                  x_q       <= x_adv_d;
                  y_q       <= y_adv_d;
                  in_rem_q  <= in_adv_d;
                  out_rem_q <= out_adv_d;
                  done_q    <= adv_done_d;
               end else begin
                  state_q  <= S_WRITE;
                  wr_req_q <= 1'b1;
               end
            end
            S_WRITE: begin
               if (wr.wr_ack) begin
                  wr_req_q  <= 1'b0;
                  state_q   <= adv_state_d;
                  x_q       <= x_adv_d;
                  y_q       <= y_adv_d;
                  in_rem_q  <= in_adv_d;
                  out_rem_q <= out_adv_d;
                  done_q    <= adv_done_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               wr_req_q <= 1'b0;
               done_q   <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign wr.wr_req = wr_req_q;
   assign wr.wr_x   = x_q;
   assign wr.wr_y   = y_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_a1_clip_seq.sv
// Self-checking bench for a1_clip_seq: directed scenarios plus randomized
// commands checked against a loop-based reference of the pixel walk.
module tb_a1_clip_seq;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        start;
   logic        clip_en;
   logic [15:0] x_start, y_start;
   logic        x_dir;
   logic [15:0] inner_cnt, outer_cnt;
   logic [14:0] win_x, win_y;
   logic        busy, done;
   logic [15:0] clip_cnt;

   a1_clip_seq_if wr_if ();

   a1_clip_seq dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .start     (start),
      .clip_en   (clip_en),
      .x_start   (x_start),
      .y_start   (y_start),
      .x_dir     (x_dir),
      .inner_cnt (inner_cnt),
      .outer_cnt (outer_cnt),
      .win_x     (win_x),
      .win_y     (win_y),
      .wr        (wr_if.master),
      .busy      (busy),
      .done      (done),
      .clip_cnt  (clip_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_log[$];
   logic [15:0] exp_clip;
   logic [31:0] wr_log[$];
   int          done_cycle, done_cnt, busy_cycles, req_cycles, stable_err;
   bit          timeout;
   logic [15:0] clip_seen;

   // Reference: enumerate the rectangle pixel by pixel with plain arithmetic.
   task automatic model(input logic [15:0] xs, input logic [15:0] ys, input logic dir,
                        input int inn, input int outr, input int wx, input int wy, input logic ce);
      logic [15:0] x, y;
      bit          outside;
      exp_log.delete();
      exp_clip = 16'd0;
      for (int o = 0; o < outr; o++) begin
         for (int i = 0; i < inn; i++) begin
            y = ys + 16'(o);
            x = dir ? (xs - 16'(i)) : (xs + 16'(i));
            outside = (int'(x) >= 32768) || (int'(y) >= 32768) ||
                      ((int'(x) % 32768) >= wx) || ((int'(y) % 32768) >= wy);
            if (outside && ce) begin
               if (exp_clip != 16'hFFFF) exp_clip = exp_clip + 16'd1;
            end else begin
               exp_log.push_back({x, y});
            end
         end
      end
   endtask

   // Issue one command and record everything the DUT does until it returns idle.
   // mode 0: ack always high, 1: random ack, 2: stall pixel stall_pix for stall_len cycles.
   task automatic run_cmd(input logic [15:0] xs, input logic [15:0] ys, input logic dir,
                          input logic [15:0] inn, input logic [15:0] outr,
                          input logic [14:0] wx, input logic [14:0] wy, input logic ce,
                          input int mode, input int stall_pix, input int stall_len, input bit poke);
      int          cyc, waited;
      bit          pend, poked, seen_done, a;
      logic [15:0] px, py;
      wr_log.delete();
      done_cycle = -1; done_cnt = 0; busy_cycles = 0; req_cycles = 0;
      stable_err = 0; timeout = 0;
      @(negedge sys_clk);
      x_start = xs; y_start = ys; x_dir = dir; inner_cnt = inn; outer_cnt = outr;
      win_x = wx; win_y = wy; clip_en = ce; start = 1'b1;
      wr_if.wr_ack = (mode == 0);
      @(negedge sys_clk);
      start = 1'b0;
      x_start = 16'($urandom); y_start = 16'($urandom); x_dir = 1'($urandom);
      inner_cnt = 16'($urandom); outer_cnt = 16'($urandom);
      win_x = 15'($urandom); win_y = 15'($urandom); clip_en = 1'($urandom);
      cyc = 1; waited = 0; pend = 0; poked = 0; seen_done = 0; px = 16'd0; py = 16'd0;
      while (1) begin
         start = 1'b0;
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = cyc;
            seen_done = 1;
         end
         if (pend && (!wr_if.wr_req || wr_if.wr_x !== px || wr_if.wr_y !== py)) stable_err++;
         if (wr_if.wr_req) begin
            req_cycles++;
            case (mode)
               0:       a = 1'b1;
               1:       a = ($urandom_range(0, 2) != 0);
               default: a = !((wr_log.size() == stall_pix) && (waited < stall_len));
            endcase
            if (!a) waited++;
            if (mode == 2 && poke && !a && waited == 2 && !poked) begin
               start = 1'b1;
               poked = 1;
            end
            wr_if.wr_ack = a;
            if (a) begin
               wr_log.push_back({wr_if.wr_x, wr_if.wr_y});
               pend = 0;
            end else begin
               pend = 1; px = wr_if.wr_x; py = wr_if.wr_y;
            end
         end else begin
            wr_if.wr_ack = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pend = 0;
         end
         if (seen_done && !busy) break;
         if (cyc >= 3000) begin
            timeout = 1;
            break;
         end
         @(negedge sys_clk);
         cyc++;
      end
      clip_seen = clip_cnt;
      wr_if.wr_ack = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; wr_if.wr_ack = 1'b0;
      clip_en = 1'b0; x_start = 16'd0; y_start = 16'd0; x_dir = 1'b0;
      inner_cnt = 16'd0; outer_cnt = 16'd0; win_x = 15'd0; win_y = 15'd0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({wr_if.wr_req, busy, done, clip_cnt, wr_if.wr_x, wr_if.wr_y} !== 51'd0) begin
         errors++;
         $display("FAIL reset_values: got req=%b busy=%b done=%b clip=%h x=%h y=%h, want all 0",
                  wr_if.wr_req, busy, done, clip_cnt, wr_if.wr_x, wr_if.wr_y);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_walk();
      model(16'd2, 16'd3, 1'b0, 3, 2, 100, 100, 1'b0);
      run_cmd(16'd2, 16'd3, 1'b0, 16'd3, 16'd2, 15'd100, 15'd100, 1'b0, 0, 0, 0, 0);
      checks++;
      if (timeout || wr_log != exp_log || exp_log.size() != 6) begin
         errors++;
         $display("FAIL basic_writes: got %0d writes (timeout=%0d), want 6 matching (2,3)..(4,4)", wr_log.size(), timeout);
      end
      checks++;
      if (done_cycle != 13) begin
         errors++; $display("FAIL basic_done_cycle: got %0d want 13", done_cycle);
      end
      checks++;
      if (clip_seen !== 16'd0 || done_cnt != 1 || busy_cycles != 13) begin
         errors++;
         $display("FAIL basic_status: clip=%h done_cnt=%0d busy=%0d, want 0/1/13", clip_seen, done_cnt, busy_cycles);
      end
   endtask

   task automatic test_clipping();
      for (int ce = 1; ce >= 0; ce--) begin
         model(16'hFFFE, 16'd5, 1'b0, 4, 1, 2, 100, 1'(ce));
         run_cmd(16'hFFFE, 16'd5, 1'b0, 16'd4, 16'd1, 15'd2, 15'd100, 1'(ce), 0, 0, 0, 0);
         checks++;
         if (timeout || wr_log != exp_log || wr_log.size() != (ce ? 2 : 4)) begin
            errors++;
            $display("FAIL clip_writes_ce%0d: got %0d writes, want %0d", ce, wr_log.size(), exp_log.size());
         end
         checks++;
         if (clip_seen !== exp_clip || clip_seen !== (ce ? 16'd2 : 16'd0)) begin
            errors++; $display("FAIL clip_count_ce%0d: got %0d want %0d", ce, clip_seen, exp_clip);
         end
      end
   endtask

   task automatic test_backpressure();
      model(16'd2, 16'd3, 1'b0, 3, 2, 100, 100, 1'b0);
      run_cmd(16'd2, 16'd3, 1'b0, 16'd3, 16'd2, 15'd100, 15'd100, 1'b0, 2, 1, 5, 1);
      checks++;
      if (stable_err != 0) begin
         errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stable_err);
      end
      checks++;
      if (timeout || wr_log != exp_log) begin
         errors++; $display("FAIL stall_writes: got %0d writes want %0d", wr_log.size(), exp_log.size());
      end
      checks++;
      if (done_cycle != 18 || req_cycles != 11) begin
         errors++; $display("FAIL stall_timing: done at %0d req %0d, want 18/11", done_cycle, req_cycles);
      end
   endtask

   task automatic test_zero_count();
      run_cmd(16'd7, 16'd7, 1'b0, 16'd0, 16'd5, 15'd100, 15'd100, 1'b1, 0, 0, 0, 0);
      checks++;
      if (timeout || done_cycle != 1 || req_cycles != 0 || busy_cycles != 1 || clip_seen !== 16'd0) begin
         errors++;
         $display("FAIL zero_count: done@%0d req=%0d busy=%0d clip=%0d, want 1/0/1/0",
                  done_cycle, req_cycles, busy_cycles, clip_seen);
      end
   endtask

   task automatic test_left_wrap();
      model(16'd1, 16'd2, 1'b1, 3, 1, 10, 10, 1'b1);
      run_cmd(16'd1, 16'd2, 1'b1, 16'd3, 16'd1, 15'd10, 15'd10, 1'b1, 0, 0, 0, 0);
      checks++;
      if (timeout || wr_log != exp_log || wr_log.size() != 2) begin
         errors++; $display("FAIL left_writes: got %0d writes want 2 at X=1,0", wr_log.size());
      end
      checks++;
      if (clip_seen !== 16'd1 || done_cycle != 6) begin
         errors++; $display("FAIL left_status: clip=%0d done@%0d want 1/6", clip_seen, done_cycle);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit bad;
      @(negedge sys_clk);
      x_start = 16'hFFFE; y_start = 16'd5; x_dir = 1'b0; inner_cnt = 16'd4; outer_cnt = 16'd1;
      win_x = 15'd2; win_y = 15'd100; clip_en = 1'b1; start = 1'b1; wr_if.wr_ack = 1'b0;
      @(negedge sys_clk);
      start = 1'b0;
      n = 0;
      while (!wr_if.wr_req && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (!wr_if.wr_req || clip_cnt !== 16'd2) begin
         errors++; $display("FAIL rst_mid_setup: req=%b clip=%0d want 1/2", wr_if.wr_req, clip_cnt);
      end
      wr_if.wr_ack = 1'b1; reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      checks++;
      if ({wr_if.wr_req, busy, done, clip_cnt, wr_if.wr_x, wr_if.wr_y} !== 51'd0) begin
         errors++;
         $display("FAIL rst_mid_values: req=%b busy=%b done=%b clip=%h x=%h y=%h, want all 0",
                  wr_if.wr_req, busy, done, clip_cnt, wr_if.wr_x, wr_if.wr_y);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         if (wr_if.wr_req || busy || done) bad = 1;
      end
      wr_if.wr_ack = 1'b0;
      checks++;
      if (bad) begin
         errors++; $display("FAIL rst_mid_quiet: got activity after reset, want none");
      end
      model(16'd2, 16'd3, 1'b0, 3, 2, 100, 100, 1'b0);
      run_cmd(16'd2, 16'd3, 1'b0, 16'd3, 16'd2, 15'd100, 15'd100, 1'b0, 0, 0, 0, 0);
      checks++;
      if (timeout || wr_log != exp_log || done_cycle != 13) begin
         errors++; $display("FAIL rst_mid_rerun: %0d writes done@%0d want 6/13", wr_log.size(), done_cycle);
      end
   endtask

   task automatic test_random();
      logic [15:0] xs, ys;
      logic        dir, ce;
      int          inn, outr, wx, wy;
      for (int t = 0; t < 10; t++) begin
         case ($urandom_range(0, 3))
            0:       xs = 16'h7FFE;
            1:       xs = 16'hFFFE;
            2:       xs = 16'h0001;
            default: xs = 16'($urandom_range(0, 31));
         endcase
         case ($urandom_range(0, 2))
            0:       ys = 16'h7FFF;
            1:       ys = 16'hFFFF;
            default: ys = 16'($urandom_range(0, 31));
         endcase
         dir = 1'($urandom); ce = 1'($urandom);
         inn = $urandom_range(0, 5); outr = $urandom_range(0, 3);
         wx = $urandom_range(0, 31); wy = $urandom_range(0, 31);
         model(xs, ys, dir, inn, outr, wx, wy, ce);
         run_cmd(xs, ys, dir, 16'(inn), 16'(outr), 15'(wx), 15'(wy), ce, 1, 0, 0, 0);
         checks++;
         if (timeout || wr_log != exp_log || clip_seen !== exp_clip || done_cnt != 1 || stable_err != 0) begin
            errors++;
            $display("FAIL random_%0d: writes %0d clip %0d done %0d unstable %0d, want writes %0d clip %0d done 1 unstable 0",
                     t, wr_log.size(), clip_seen, done_cnt, stable_err, exp_log.size(), exp_clip);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_walk();
      test_clipping();
      test_backpressure();
      test_zero_count();
      test_left_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
